// File: rtl/uart_pkg.sv
// Shared UART constants and state encodings for the receiver and the later transmitter.
package uart_pkg;

  localparam int UART_OVS       = 16;
  localparam int UART_MID       = 8;
  localparam int UART_DATA_BITS = 8;

  localparam logic [2:0] UART_ST_IDLE  = 3'd0;
  localparam logic [2:0] UART_ST_START = 3'd1;
  localparam logic [2:0] UART_ST_DATA  = 3'd2;
  localparam logic [2:0] UART_ST_STOP  = 3'd3;
  localparam logic [2:0] UART_ST_BREAK = 3'd4;

  typedef enum logic [2:0] {
    ST_IDLE  = UART_ST_IDLE,
    ST_START = UART_ST_START,
    ST_DATA  = UART_ST_DATA,
    ST_STOP  = UART_ST_STOP,
    ST_BREAK = UART_ST_BREAK
  } uart_state_e;

endpackage

// File: rtl/uart_baud_tick.sv
// Oversampling tick generator: divisor down-counter, one tick per (div_i+1) cycles.
module uart_baud_tick #(
  parameter int DIV_WIDTH = 16
) (
  input  logic                 clk_in,
  input  logic                 rst_n,
  input  logic [DIV_WIDTH-1:0] div_i,
  input  logic                 restart_i,
  output logic                 tick_o
);

  logic [DIV_WIDTH-1:0] cnt_q;
  logic [DIV_WIDTH-1:0] cnt_d;

  // A restart reloads without ticking so the next tick lands div_i+1 cycles after the edge.
  always_comb begin
    tick_o = (cnt_q == '0) && !restart_i;
    if (restart_i || (cnt_q == '0)) begin
      cnt_d = div_i;
    end else begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: 2-flop line synchroniser, 16x oversampling deframer, one-entry holding register.
module uart_rx
  import uart_pkg::*;
#(
  parameter int DIV_WIDTH = 16,
  parameter int OVS       = UART_OVS
) (
  input  logic                 clk_in,
  input  logic                 rst_n,
  input  logic                 pad_uart_rx,
  input  logic                 cfg_en,
  input  logic [DIV_WIDTH-1:0] cfg_div,
  input  logic                 rx_ready,
  input  logic                 clr_overrun,
  output logic [7:0]           rx_data,
  output logic                 rx_valid,
  output logic                 rx_frame_err,
  output logic                 rx_overrun,
  output logic                 rx_busy,
  output logic [2:0]           dbg_state
);

  localparam int SCNT_W = $clog2(OVS);
  localparam logic [SCNT_W-1:0] SCNT_LAST = SCNT_W'(OVS - 1);
  localparam logic [SCNT_W-1:0] SCNT_MID  = SCNT_W'(UART_MID - 1);
  localparam logic [2:0]        BCNT_LAST = 3'(UART_DATA_BITS - 1);

  logic        sync1_q;
  logic        sync2_q;
  logic        hist_q;
  logic        line;
  logic        fall;
  logic        start_edge;
  logic        tick;
  logic        byte_done;
  logic        xfer;
  logic        drop;

  uart_state_e       state_q;
  logic [SCNT_W-1:0] scnt_q;
  logic [2:0]        bcnt_q;
  logic [7:0]        shreg_q;
  logic [7:0]        data_q;
  logic              valid_q;
  logic              ferr_q;
  logic              ovr_q;

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      hist_q  <= 1'b1;
    end else begin
      sync1_q <= pad_uart_rx;
      sync2_q <= sync1_q;
      hist_q  <= sync2_q;
    end
  end

  assign line       = sync2_q;
  assign fall       = hist_q && !sync2_q;
  assign start_edge = cfg_en && (state_q == ST_IDLE) && fall;

  uart_baud_tick #(
    .DIV_WIDTH (DIV_WIDTH)
  ) u_tick (
    .clk_in    (clk_in),
    .rst_n     (rst_n),
    .div_i     (cfg_div),
    .restart_i (start_edge),
    .tick_o    (tick)
  );

  // Handshake: a byte transfers on a cycle where rx_valid and rx_ready are both high;
  // rx_data/rx_frame_err hold steady while rx_valid is high, and a byte arriving while
  // the holder is full and not being drained is dropped and flagged as overrun.
  always_comb begin
    byte_done = cfg_en && (state_q == ST_STOP) && tick && (scnt_q == SCNT_LAST);
    xfer      = valid_q && rx_ready;
    drop      = byte_done && valid_q && !rx_ready;
  end

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      scnt_q  <= '0;
      bcnt_q  <= '0;
      shreg_q <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      if (drop) begin
        ovr_q <= 1'b1;
      end else if (clr_overrun) begin
        ovr_q <= 1'b0;
      end

      if (byte_done && !drop) begin
        data_q  <= shreg_q;
        ferr_q  <= !line;
        valid_q <= 1'b1;
      end else if (xfer) begin
        valid_q <= 1'b0;
      end

      if (!cfg_en) begin
        state_q <= ST_IDLE;
      end else begin
        case (state_q)
          ST_IDLE: begin
            if (fall) begin
              state_q <= ST_START;
              scnt_q  <= '0;
            end
          end
          ST_START: begin
            if (tick) begin
              if (scnt_q == SCNT_MID) begin
                // A start bit that is high again at mid-bit was only a glitch.
                if (!line) begin
                  state_q <= ST_DATA;
                  scnt_q  <= '0;
                  bcnt_q  <= '0;
                end else begin
                  state_q <= ST_IDLE;
                end
              end else begin
                scnt_q <= scnt_q + 1'b1;
              end
            end
          end
          ST_DATA: begin
            if (tick) begin
              scnt_q <= scnt_q + 1'b1;
              if (scnt_q == SCNT_LAST) begin
                shreg_q <= {line, shreg_q[7:1]};
                if (bcnt_q == BCNT_LAST) begin
                  state_q <= ST_STOP;
                end else begin
                  bcnt_q <= bcnt_q + 1'b1;
                end
              end
            end
          end
          ST_STOP: begin
            if (tick) begin
              scnt_q <= scnt_q + 1'b1;
              if (scnt_q == SCNT_LAST) begin
                state_q <= line ? ST_IDLE : ST_BREAK;
              end
            end
          end
          ST_BREAK: begin
            if (line) begin
              state_q <= ST_IDLE;
            end
          end
          default: begin
            state_q <= ST_IDLE;
          end
        endcase
      end
    end
  end

  assign rx_data      = data_q;
  assign rx_valid     = valid_q;
  assign rx_frame_err = ferr_q;
  assign rx_overrun   = ovr_q;
  assign rx_busy      = (state_q != ST_IDLE);
  assign dbg_state    = state_q;

endmodule

// File: tb/tb_uart_rx.sv
// Directed and randomized 8N1 frames driven into uart_rx, checked against a frame-level model.
module tb_uart_rx;
  import uart_pkg::*;

  logic        clk_in;
  logic        rst_n;
  logic        pad_uart_rx;
  logic        cfg_en;
  logic [15:0] cfg_div;
  logic        rx_ready;
  logic        clr_overrun;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_frame_err;
  logic        rx_overrun;
  logic        rx_busy;
  logic [2:0]  dbg_state;

  int n_checks = 0;
  int n_fails  = 0;

  logic [8:0] exp_q[$];
  logic [8:0] got_q[$];

  uart_rx #(.DIV_WIDTH(16)) dut (
    .clk_in       (clk_in),
    .rst_n        (rst_n),
    .pad_uart_rx  (pad_uart_rx),
    .cfg_en       (cfg_en),
    .cfg_div      (cfg_div),
    .rx_ready     (rx_ready),
    .clr_overrun  (clr_overrun),
    .rx_data      (rx_data),
    .rx_valid     (rx_valid),
    .rx_frame_err (rx_frame_err),
    .rx_overrun   (rx_overrun),
    .rx_busy      (rx_busy),
    .dbg_state    (dbg_state)
  );

  initial begin
    clk_in = 1'b0;
    forever #5 clk_in = ~clk_in;
  end

  // Every handshake transfer, as {frame_err, data}.
  always begin
    @(negedge clk_in);
    #1;
    if (rx_valid === 1'b1 && rx_ready === 1'b1) got_q.push_back({rx_frame_err, rx_data});
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_queue(input string tag);
    check({tag, "_count"}, got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) check(tag, 32'(got_q[i]), 32'(exp_q[i]));
    got_q.delete();
    exp_q.delete();
  endtask

  // One 8N1 frame, LSB first, each bit held 16*d cycles; line left at the stop value.
  task automatic send_frame(input logic [7:0] b, input logic stop_b, input int d);
    logic [9:0] fr;
    fr = {stop_b, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      pad_uart_rx = fr[i];
      repeat (16 * d) @(negedge clk_in);
    end
  endtask

  initial begin
    int n;
    int d;
    int lat_exp;
    logic [7:0] b;
    logic stop_b;

    rst_n       = 1'b0;
    pad_uart_rx = 1'b1;
    cfg_en      = 1'b1;
    cfg_div     = 16'd0;
    rx_ready    = 1'b1;
    clr_overrun = 1'b0;
    repeat (3) @(negedge clk_in);
    check("rst_data",  32'(rx_data), 32'h0);
    check("rst_valid", 32'(rx_valid), 32'h0);
    check("rst_ferr",  32'(rx_frame_err), 32'h0);
    check("rst_ovr",   32'(rx_overrun), 32'h0);
    check("rst_busy",  32'(rx_busy), 32'h0);
    check("rst_state", 32'(dbg_state), 32'(UART_ST_IDLE));
    rst_n = 1'b1;
    repeat (5) @(negedge clk_in);

    // 0x55 at cfg_div=0: valid appears 2 sync cycles + 9.5 bits + 1 cycle after the start edge.
    d = 1;
    lat_exp = 2 + (16 * 19 / 2) * d + 1;
    exp_q.push_back({1'b0, 8'h55});
    fork
      send_frame(8'h55, 1'b1, d);
      begin
        n = 0;
        while (rx_valid !== 1'b1 && n < 2000) begin
          @(negedge clk_in);
          n++;
        end
        check("t1_latency", n, lat_exp);
        check("t1_data", 32'(rx_data), 32'h55);
        check("t1_ferr", 32'(rx_frame_err), 32'h0);
        @(negedge clk_in);
        check("t1_pulse", 32'(rx_valid), 32'h0);
      end
    join
    repeat (4) @(negedge clk_in);
    check_queue("t1_q");

    // Back-to-back frames at cfg_div=3.
    cfg_div = 16'd3;
    d = 4;
    repeat (4) @(negedge clk_in);
    exp_q.push_back({1'b0, 8'hA3});
    exp_q.push_back({1'b0, 8'h0F});
    send_frame(8'hA3, 1'b1, d);
    check("t2_busy_gap", 32'(rx_busy), 32'h0);
    fork
      send_frame(8'h0F, 1'b1, d);
      begin
        repeat (50 * d) @(negedge clk_in);
        check("t2_busy_mid", 32'(rx_busy), 32'h1);
      end
    join
    repeat (4) @(negedge clk_in);
    check("t2_ovr", 32'(rx_overrun), 32'h0);
    check_queue("t2_q");

    // Short low glitch: START aborts.
    pad_uart_rx = 1'b0;
    repeat (3 * d) @(negedge clk_in);
    check("t3_start", 32'(dbg_state), 32'(UART_ST_START));
    repeat (2 * d) @(negedge clk_in);
    pad_uart_rx = 1'b1;
    repeat (20 * d) @(negedge clk_in);
    check("t3_busy",  32'(rx_busy), 32'h0);
    check("t3_valid", 32'(rx_valid), 32'h0);
    check("t3_ferr",  32'(rx_frame_err), 32'h0);
    check("t3_ovr",   32'(rx_overrun), 32'h0);
    check_queue("t3_q");

    // Framing error followed by a held-low break, then a good byte.
    exp_q.push_back({1'b1, 8'h81});
    send_frame(8'h81, 1'b0, d);
    repeat (40 * d) @(negedge clk_in);
    check("t4_break", 32'(dbg_state), 32'(UART_ST_BREAK));
    check("t4_data",  32'(rx_data), 32'h81);
    check("t4_ferr",  32'(rx_frame_err), 32'h1);
    pad_uart_rx = 1'b1;
    repeat (4) @(negedge clk_in);
    check("t4_idle", 32'(dbg_state), 32'(UART_ST_IDLE));
    exp_q.push_back({1'b0, 8'h42});
    send_frame(8'h42, 1'b1, d);
    repeat (4) @(negedge clk_in);
    check_queue("t4_q");

    // Overrun with consumer stalled.
    rx_ready = 1'b0;
    send_frame(8'h11, 1'b1, d);
    check("t5_valid1", 32'(rx_valid), 32'h1);
    check("t5_data1",  32'(rx_data), 32'h11);
    check("t5_ovr1",   32'(rx_overrun), 32'h0);
    send_frame(8'h22, 1'b1, d);
    check("t5_data2", 32'(rx_data), 32'h11);
    check("t5_ovr2",  32'(rx_overrun), 32'h1);
    check("t5_valid2", 32'(rx_valid), 32'h1);
    clr_overrun = 1'b1;
    @(negedge clk_in);
    clr_overrun = 1'b0;
    @(negedge clk_in);
    check("t5_clr", 32'(rx_overrun), 32'h0);
    exp_q.push_back({1'b0, 8'h11});
    rx_ready = 1'b1;
    @(negedge clk_in);
    check("t5_drain", 32'(rx_valid), 32'h0);
    repeat (2) @(negedge clk_in);
    check_queue("t5_q");

    // Receiver disabled mid-frame: partial byte discarded.
    fork
      send_frame(8'h5A, 1'b1, d);
      begin
        repeat (40 * d) @(negedge clk_in);
        cfg_en = 1'b0;
        @(negedge clk_in);
        check("t6_abort", 32'(rx_busy), 32'h0);
      end
    join
    repeat (4) @(negedge clk_in);
    cfg_en = 1'b1;
    repeat (16 * d) @(negedge clk_in);
    check("t6_valid", 32'(rx_valid), 32'h0);
    check_queue("t6_q");

    // Reset during data bit 4 of 0xFF.
    fork
      send_frame(8'hFF, 1'b1, d);
      begin
        repeat ((5 * 16 + 8) * d) @(negedge clk_in);
        rst_n = 1'b0;
        #1;
        check("t7_data",  32'(rx_data), 32'h0);
        check("t7_valid", 32'(rx_valid), 32'h0);
        check("t7_ferr",  32'(rx_frame_err), 32'h0);
        check("t7_ovr",   32'(rx_overrun), 32'h0);
        check("t7_busy",  32'(rx_busy), 32'h0);
        repeat (3) @(negedge clk_in);
        rst_n = 1'b1;
      end
    join
    repeat (4) @(negedge clk_in);
    exp_q.push_back({1'b0, 8'h3C});
    send_frame(8'h3C, 1'b1, d);
    repeat (4) @(negedge clk_in);
    check_queue("t7_q");

    // Random bytes, stop bits and divisors.
    for (int r = 0; r < 8; r++) begin
      n = 0;
      while (rx_busy !== 1'b0 && n < 500) begin
        @(negedge clk_in);
        n++;
      end
      d = $urandom_range(1, 4);
      cfg_div = 16'(d - 1);
      b = 8'($urandom_range(0, 255));
      stop_b = ($urandom_range(0, 3) != 0);
      exp_q.push_back({~stop_b, b});
      send_frame(b, stop_b, d);
      pad_uart_rx = 1'b1;
      repeat (4 + $urandom_range(0, 2) * 16 * d) @(negedge clk_in);
    end
    repeat (4) @(negedge clk_in);
    check_queue("rnd_q");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- UART receiver: the consumer end of the pad_uart_rx path leaving the chip port multiplexer.
- Synchronises the asynchronous pad line and oversamples it at 16x.
- Deframes 8N1 characters, LSB first.
- Presents each byte through a one-entry valid/ready holding register to the peripheral bus side, with framing-error and overrun status.

Parameters:
- DIV_WIDTH, 16, width of the baud divisor input.
- OVS, 16, oversampling ticks per bit. Fixed at 16; not to be overridden.

Ports:
- clk_in  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- pad_uart_rx  input  1  serial line from port mux; asynchronous, idle high
- cfg_en  input  1  receiver enable
- cfg_div  input  DIV_WIDTH  tick period minus one, in clk_in cycles; bit period = 16*(cfg_div+1) cycles
- rx_ready  input  1  consumer accepts byte
- clr_overrun  input  1  one-cycle pulse, clears rx_overrun
- rx_data  output  8  received byte
- rx_valid  output  1  rx_data/rx_frame_err valid
- rx_frame_err  output  1  stop bit of the held byte sampled low
- rx_overrun  output  1  sticky: a byte was dropped
- rx_busy  output  1  FSM not in IDLE

Behaviour:
- Clock and reset: one clock, clk_in. Reset rst_n is asynchronous, active-low. Reset values: rx_data=0, rx_valid=0, rx_frame_err=0, rx_overrun=0, rx_busy=0, FSM=IDLE, synchroniser flops=1, tick counter=0.
- Synchroniser:
  - 2 flops on pad_uart_rx, plus 1 history flop for edge detect.
  - The line is seen internally 2 cycles late.
- Tick generator:
  - Down-counter reloads cfg_div when it reaches 0; a tick is emitted on the reload cycle.
  - cfg_div=0 gives a tick every cycle.
  - Counter restarts (reloads) when a start edge is detected, aligning ticks to the edge.
- FSM, sample counter scnt 0..15 and bit counter bcnt 0..7:
  - IDLE: on a synced falling edge with cfg_en=1, go to START with scnt=0.
  - START: counts ticks. At tick 8 (mid-bit), sample the line. If 0, go to DATA with scnt=0, bcnt=0. If 1, treat as a glitch and return to IDLE with no status change.
  - DATA: every 16th tick, sample and shift into the shift register from the MSB (shift right). After bcnt=7, go to STOP.
  - STOP: at the 16th tick, sample.
    - Sample=1: load the holding register, go to IDLE.
    - Sample=0: load with frame_err=1, go to BREAK.
  - BREAK: wait for synced line=1, then go to IDLE. No new start is detected while low.
- Holding register and handshake:
  - rx_valid rises the cycle after the stop sample tick.
  - rx_data and rx_frame_err are stable while rx_valid=1.
  - Transfer occurs on rx_valid & rx_ready. rx_valid clears next cycle unless a new byte loads in that same cycle.
  - A byte completes while rx_valid=1 and rx_ready=0: the new byte is dropped, the old one is kept, rx_overrun is set.
  - A byte completes in the same cycle as a transfer: the new byte loads, rx_valid stays 1, no overrun.
  - rx_overrun clears on clr_overrun. A set in the same cycle as the clear wins.
- cfg_en deasserted mid-frame: FSM returns to IDLE the next cycle and the partial byte is discarded. The holding register and rx_overrun are retained.
- cfg_div change mid-frame: undefined timing for that frame only. Software changes it only while rx_busy=0.
- Reset mid-frame: all state returns to reset values immediately. The partial byte is lost.

Decomposition:
- Shared include file (alongside the chip parameter include) holds:
  - UART_OVS=16, UART_MID=8, UART_DATA_BITS=8
  - FSM state encodings IDLE/START/DATA/STOP/BREAK as 3-bit localparams, reused by the future uart_tx.
- One sub-module: uart_baud_tick (divisor down-counter with restart input and tick output), shared later with the transmitter.

Test Plan:
- cfg_div=0, send 0x55 as 8N1 at 16 cycles/bit, rx_ready=1 -> one rx_valid pulse with rx_data=0x55 and rx_frame_err=0; rx_valid rises 1 cycle after the stop mid-sample.
- cfg_div=3, send 0xA3 then 0x0F back-to-back, rx_ready=1 -> 0xA3 then 0x0F, no overrun, rx_busy low only between the frames.
- Low glitch of 5 ticks on the idle line -> START aborts to IDLE, no rx_valid, flags unchanged.
- Send 0x81 with stop bit 0, then hold the line low for 40 ticks -> rx_data=0x81, rx_frame_err=1; FSM stays in BREAK until the line rises, then the next byte 0x42 is received correctly.
- rx_ready=0, send 0x11 then 0x22 -> rx_data stays 0x11, rx_overrun=1 after the second stop. Pulse clr_overrun -> rx_overrun=0. Raise rx_ready -> rx_valid=0 the next cycle.
- Assert rst_n=0 during DATA bit 4 of 0xFF -> all outputs at reset values at once. After release, 0x3C is received correctly.
